// File: rtl/mesh_task_ctrl.sv
// Test-task sequencer for the 2x4 mesh: shadows per-PE traffic config,
// runs flush/run/end sequencing and collects sticky per-PE finish status.
module mesh_task_ctrl #(
  parameter int NUM_PE    = 8,
  parameter int FLUSH_CYC = 4,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [3:0]            cfg_wr_addr,
  input  logic [31:0]           cfg_wr_data,
  input  logic                  start,
  input  logic                  abort,
  output logic [NUM_PE-1:0]     pe_enable,
  output logic [NUM_PE-1:0]     pe_dbg_mode_wire,
  output logic [3*NUM_PE-1:0]   pe_send_num_wire,
  output logic [3*NUM_PE-1:0]   pe_receive_num_wire,
  output logic [4*NUM_PE-1:0]   pe_rate_wire,
  output logic [24*NUM_PE-1:0]  pe_dst_seq_wire,
  output logic [4*NUM_PE-1:0]   pe_mode_wire,
  output logic [NUM_PE-1:0]     pe_flush_wire,
  input  logic [NUM_PE-1:0]     pe_task_send_finish_flag,
  input  logic [NUM_PE-1:0]     pe_task_receive_finish_flag,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [NUM_PE-1:0]     send_done_mask,
  output logic [NUM_PE-1:0]     recv_done_mask,
  output logic [CNT_W-1:0]      run_cycles
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;
  localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  logic [1:0]           state_r;
  logic [FC_W-1:0]      flush_cnt_r;
  logic [NUM_PE-1:0]    mask_r;
  logic [NUM_PE-1:0]    dbg_r;
  logic [3*NUM_PE-1:0]  send_num_r;
  logic [3*NUM_PE-1:0]  recv_num_r;
  logic [4*NUM_PE-1:0]  rate_r;
  logic [4*NUM_PE-1:0]  mode_r;
  logic [24*NUM_PE-1:0] dst_seq_r;
  logic [CNT_W-1:0]     limit_r;
  logic [CNT_W-1:0]     run_cycles_r;
  logic [NUM_PE-1:0]    send_done_r;
  logic [NUM_PE-1:0]    recv_done_r;
  logic                 done_r;
  logic                 timeout_r;

  logic                 busy_s;
  logic                 start_ok_s;
  logic [NUM_PE-1:0]    send_nxt_s;
  logic [NUM_PE-1:0]    recv_nxt_s;
  logic                 complete_s;
  logic                 tmo_hit_s;
  logic [CNT_W-1:0]     run_inc_s;

  assign busy_s     = (state_r == ST_FLUSH) || (state_r == ST_RUN);
  assign start_ok_s = start && (mask_r != {NUM_PE{1'b0}}) && !busy_s;
  assign send_nxt_s = send_done_r | (pe_task_send_finish_flag & mask_r);
  assign recv_nxt_s = recv_done_r | (pe_task_receive_finish_flag & mask_r);
  // Completion looks at this cycle's flags too, so END follows immediately.
  assign complete_s = (send_nxt_s == mask_r) && (recv_nxt_s == mask_r);
  assign tmo_hit_s  = (limit_r != {CNT_W{1'b0}}) &&
                      (run_cycles_r == (limit_r - {{(CNT_W-1){1'b0}}, 1'b1}));
  assign run_inc_s  = (run_cycles_r == {CNT_W{1'b1}}) ? run_cycles_r
                      : run_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Shadow configuration registers, frozen while a task is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r     <= {NUM_PE{1'b0}};
      dbg_r      <= {NUM_PE{1'b0}};
      send_num_r <= {(3*NUM_PE){1'b0}};
      recv_num_r <= {(3*NUM_PE){1'b0}};
      rate_r     <= {(4*NUM_PE){1'b0}};
      mode_r     <= {(4*NUM_PE){1'b0}};
      dst_seq_r  <= {(24*NUM_PE){1'b0}};
      limit_r    <= {CNT_W{1'b0}};
    end else if (cfg_wr_en && !busy_s) begin
      case (cfg_wr_addr)
        4'd0: begin
          mask_r <= cfg_wr_data[NUM_PE-1:0];
          dbg_r  <= cfg_wr_data[8 +: NUM_PE];
        end
        4'd1:  send_num_r <= cfg_wr_data[3*NUM_PE-1:0];
        4'd2:  recv_num_r <= cfg_wr_data[3*NUM_PE-1:0];
        4'd3:  rate_r <= cfg_wr_data[4*NUM_PE-1:0];
        4'd4:  mode_r <= cfg_wr_data[4*NUM_PE-1:0];
        4'd5:  dst_seq_r[31:0]    <= cfg_wr_data;
        4'd6:  dst_seq_r[63:32]   <= cfg_wr_data;
        4'd7:  dst_seq_r[95:64]   <= cfg_wr_data;
        4'd8:  dst_seq_r[127:96]  <= cfg_wr_data;
        4'd9:  dst_seq_r[159:128] <= cfg_wr_data;
        4'd10: dst_seq_r[191:160] <= cfg_wr_data;
        4'd11: limit_r <= CNT_W'(cfg_wr_data);
        default: limit_r <= limit_r;
      endcase
    end
  end

  // Task sequencer with sticky status collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      flush_cnt_r  <= {FC_W{1'b0}};
      run_cycles_r <= {CNT_W{1'b0}};
      send_done_r  <= {NUM_PE{1'b0}};
      recv_done_r  <= {NUM_PE{1'b0}};
      done_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_END: begin
          if (start_ok_s) begin
            state_r      <= ST_FLUSH;
            flush_cnt_r  <= {FC_W{1'b0}};
            run_cycles_r <= {CNT_W{1'b0}};
            send_done_r  <= {NUM_PE{1'b0}};
            recv_done_r  <= {NUM_PE{1'b0}};
            done_r       <= 1'b0;
            timeout_r    <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (abort) begin
            state_r   <= ST_END;
            timeout_r <= 1'b1;
            done_r    <= 1'b0;
          end else if (flush_cnt_r == FC_W'(FLUSH_CYC - 1)) begin
            state_r <= ST_RUN;
          end else begin
            flush_cnt_r <= flush_cnt_r + {{(FC_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_r   <= ST_END;
            timeout_r <= 1'b1;
            done_r    <= 1'b0;
          end else begin
            run_cycles_r <= run_inc_s;
            send_done_r  <= send_nxt_s;
            recv_done_r  <= recv_nxt_s;
            if (complete_s) begin
              state_r <= ST_END;
              done_r  <= 1'b1;
            end else if (tmo_hit_s) begin
              state_r   <= ST_END;
              timeout_r <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign pe_enable           = (state_r == ST_RUN)   ? mask_r : {NUM_PE{1'b0}};
  assign pe_flush_wire       = (state_r == ST_FLUSH) ? mask_r : {NUM_PE{1'b0}};
  assign pe_dbg_mode_wire    = dbg_r;
  assign pe_send_num_wire    = send_num_r;
  assign pe_receive_num_wire = recv_num_r;
  assign pe_rate_wire        = rate_r;
  assign pe_mode_wire        = mode_r;
  assign pe_dst_seq_wire     = dst_seq_r;
  assign busy                = busy_s;
  assign done                = done_r;
  assign timeout             = timeout_r;
  assign send_done_mask      = send_done_r;
  assign recv_done_mask      = recv_done_r;
  assign run_cycles          = run_cycles_r;

endmodule

// File: tb/tb_mesh_task_ctrl.sv
// Directed bench for mesh_task_ctrl: linear steps with hand-computed values.
module tb_mesh_task_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_wr_en = 1'b0;
  logic [3:0]   cfg_wr_addr = 4'd0;
  logic [31:0]  cfg_wr_data = 32'd0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   pe_enable, pe_dbg_mode_wire, pe_flush_wire;
  logic [23:0]  pe_send_num_wire, pe_receive_num_wire;
  logic [31:0]  pe_rate_wire, pe_mode_wire;
  logic [191:0] pe_dst_seq_wire;
  logic [7:0]   send_flag = 8'd0;
  logic [7:0]   recv_flag = 8'd0;
  logic         busy, done, timeout;
  logic [7:0]   send_done_mask, recv_done_mask;
  logic [31:0]  run_cycles;
  int checks = 0;
  int errors = 0;

  mesh_task_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .start(start), .abort(abort),
    .pe_enable(pe_enable), .pe_dbg_mode_wire(pe_dbg_mode_wire),
    .pe_send_num_wire(pe_send_num_wire), .pe_receive_num_wire(pe_receive_num_wire),
    .pe_rate_wire(pe_rate_wire), .pe_dst_seq_wire(pe_dst_seq_wire),
    .pe_mode_wire(pe_mode_wire), .pe_flush_wire(pe_flush_wire),
    .pe_task_send_finish_flag(send_flag), .pe_task_receive_finish_flag(recv_flag),
    .busy(busy), .done(done), .timeout(timeout),
    .send_done_mask(send_done_mask), .recv_done_mask(recv_done_mask),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    tick(1);
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_enable", pe_enable, 8'h00);
    chk("rst_flush", pe_flush_wire, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_dst_seq", pe_dst_seq_wire, 192'd0);
    rst = 1'b0;
    tick(1);

    // Normal completion
    wr(4'd0, 32'h0000_000F);
    wr(4'd1, 32'h0000_0249);
    chk("send_num_wr", pe_send_num_wire, 24'h000249);
    wr(4'd11, 32'd100);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk("t1_flush", pe_flush_wire, 8'h0F);
      chk("t1_flush_en", pe_enable, 8'h00);
      chk("t1_flush_busy", busy, 1'b1);
      tick(1);
    end
    chk("t1_run_en", pe_enable, 8'h0F);
    chk("t1_run_flush", pe_flush_wire, 8'h00);
    chk("t1_rc0", run_cycles, 32'd0);
    tick(10);
    chk("t1_rc10", run_cycles, 32'd10);
    send_flag = 8'h0F; recv_flag = 8'h0F;
    tick(1);
    send_flag = 8'h00; recv_flag = 8'h00;
    chk("t1_done", done, 1'b1);
    chk("t1_timeout", timeout, 1'b0);
    chk("t1_rc", run_cycles, 32'd11);
    chk("t1_end_en", pe_enable, 8'h00);
    chk("t1_end_busy", busy, 1'b0);
    chk("t1_smask", send_done_mask, 8'h0F);

    // Timeout with PE7 never finishing
    wr(4'd0, 32'h0000_00FF);
    wr(4'd11, 32'd20);
    pulse_start();
    chk("t2_clear_done", done, 1'b0);
    tick(4);
    send_flag = 8'h7F; recv_flag = 8'h7F;
    tick(19);
    chk("t2_rc19", run_cycles, 32'd19);
    chk("t2_busy19", busy, 1'b1);
    tick(1);
    send_flag = 8'h00; recv_flag = 8'h00;
    chk("t2_timeout", timeout, 1'b1);
    chk("t2_done", done, 1'b0);
    chk("t2_rc", run_cycles, 32'd20);
    chk("t2_smask", send_done_mask, 8'h7F);
    chk("t2_rmask", recv_done_mask, 8'h7F);
    chk("t2_busy", busy, 1'b0);

    // Staggered flags, non-enabled bits toggling, timeout disabled
    wr(4'd0, 32'h0000_000F);
    wr(4'd11, 32'd0);
    pulse_start();
    tick(4);
    send_flag = 8'hFE; recv_flag = 8'hAE;
    tick(1);
    send_flag = 8'h50; recv_flag = 8'h50;
    tick(1);
    send_flag = 8'h00; recv_flag = 8'h00;
    tick(1);
    send_flag = 8'h01; recv_flag = 8'hF0;
    tick(1);
    send_flag = 8'h00; recv_flag = 8'h00;
    chk("t3_smask", send_done_mask, 8'h0F);
    chk("t3_rmask3", recv_done_mask, 8'h0E);
    chk("t3_busy3", busy, 1'b1);
    tick(4);
    chk("t3_busy7", busy, 1'b1);
    chk("t3_done7", done, 1'b0);
    recv_flag = 8'h01;
    tick(1);
    recv_flag = 8'h00;
    chk("t3_done", done, 1'b1);
    chk("t3_rmask", recv_done_mask, 8'h0F);
    chk("t3_rc", run_cycles, 32'd9);

    // Writes and start ignored while running, then abort
    wr(4'd11, 32'd100);
    pulse_start();
    tick(4);
    tick(2);
    wr(4'd1, 32'h0000_0777);
    chk("t4_shadow", pe_send_num_wire, 24'h000249);
    pulse_start();
    chk("t4_busy", busy, 1'b1);
    chk("t4_flush", pe_flush_wire, 8'h00);
    chk("t4_en", pe_enable, 8'h0F);
    tick(1);
    chk("t4_rc5", run_cycles, 32'd5);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_done", done, 1'b0);
    chk("t4_rc", run_cycles, 32'd5);
    chk("t4_busy_end", busy, 1'b0);
    chk("t4_en_end", pe_enable, 8'h00);

    // Config map placement and zero-mask start
    wr(4'd5,  32'h0123_4567);
    wr(4'd6,  32'h89AB_CDEF);
    wr(4'd7,  32'hDEAD_BEEF);
    wr(4'd8,  32'hCAFE_F00D);
    wr(4'd9,  32'h0F0F_0F0F);
    wr(4'd10, 32'hF0E1_D2C3);
    wr(4'd12, 32'hFFFF_FFFF);
    chk("t5_dst_seq", pe_dst_seq_wire,
        {32'hF0E1_D2C3, 32'h0F0F_0F0F, 32'hCAFE_F00D,
         32'hDEAD_BEEF, 32'h89AB_CDEF, 32'h0123_4567});
    wr(4'd2, 32'h00AB_CDEF);
    chk("t5_recv_num", pe_receive_num_wire, 24'hABCDEF);
    wr(4'd3, 32'h1234_5678);
    chk("t5_rate", pe_rate_wire, 32'h1234_5678);
    wr(4'd4, 32'h8765_4321);
    chk("t5_mode", pe_mode_wire, 32'h8765_4321);
    wr(4'd0, 32'h0000_A500);
    chk("t5_dbg", pe_dbg_mode_wire, 8'hA5);
    pulse_start();
    chk("t5_zero_busy", busy, 1'b0);
    chk("t5_zero_flush", pe_flush_wire, 8'h00);
    chk("t5_status_hold", timeout, 1'b1);

    // Asynchronous reset mid-flush, then a fresh task
    wr(4'd0, 32'h0000_003C);
    pulse_start();
    tick(1);
    chk("t6_pre_flush", pe_flush_wire, 8'h3C);
    rst = 1'b1;
    #1;
    chk("t6_rst_flush", pe_flush_wire, 8'h00);
    chk("t6_rst_en", pe_enable, 8'h00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_dst", pe_dst_seq_wire, 192'd0);
    chk("t6_rst_send", pe_send_num_wire, 24'd0);
    chk("t6_rst_timeout", timeout, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    wr(4'd0, 32'h0000_0003);
    pulse_start();
    chk("t6_flush", pe_flush_wire, 8'h03);
    tick(4);
    chk("t6_en", pe_enable, 8'h03);
    send_flag = 8'h03; recv_flag = 8'h03;
    tick(1);
    send_flag = 8'h00; recv_flag = 8'h00;
    chk("t6_done", done, 1'b1);
    chk("t6_rc", run_cycles, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mesh_task_ctrl.md
Name: mesh_task_ctrl

Overview:
- Test-task sequencer directly upstream of the 2x4 mesh top.
- Holds the per-PE traffic configuration in shadow registers loaded over a simple write port, and drives the mesh's PE config inputs.
- Sequences flush, run and completion, collecting the mesh's per-PE send/receive finish flags into sticky status, with cycle count and timeout.

Parameters:
NUM_PE, 8, number of PEs; fixed output widths below assume 8
FLUSH_CYC, 4, cycles pe_flush_wire is held high before run (>=1)
CNT_W, 32, width of run-cycle counter and timeout limit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_wr_en  in  1  config write strobe, one word per cycle
cfg_wr_addr  in  4  config word address
cfg_wr_data  in  32  config write data
start  in  1  single-cycle pulse, begin task
abort  in  1  single-cycle pulse, stop task
pe_enable  out  8  per-PE enable to mesh
pe_dbg_mode_wire  out  8  per-PE debug mode
pe_send_num_wire  out  24  3 bits per PE
pe_receive_num_wire  out  24  3 bits per PE
pe_rate_wire  out  32  4 bits per PE
pe_dst_seq_wire  out  192  24 bits per PE
pe_mode_wire  out  32  4 bits per PE
pe_flush_wire  out  8  per-PE flush
pe_task_send_finish_flag  in  8  from mesh
pe_task_receive_finish_flag  in  8  from mesh
busy  out  1  FLUSH or RUN
done  out  1  task completed normally (sticky)
timeout  out  1  task ended by timeout or abort (sticky)
send_done_mask  out  8  sticky send-finish per PE
recv_done_mask  out  8  sticky receive-finish per PE
run_cycles  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset: all shadow registers, outputs, counters and status go to 0; state is IDLE.
- Config map (32-bit words):
  - 0: [7:0] enable mask, [15:8] dbg mode
  - 1: send_num[23:0]
  - 2: receive_num[23:0]
  - 3: rate
  - 4: mode
  - 5..10: dst_seq words, 5 = bits [31:0] up to 10 = bits [191:160]
  - 11: timeout limit [CNT_W-1:0]
  - Addresses 12..15 are ignored.
- Writes take effect the cycle after the strobe.
- Writes are ignored while busy=1.
- All config outputs except pe_enable and pe_flush_wire are driven combinationally from shadow registers at all times.
- State machine: IDLE, FLUSH, RUN, END.
  - IDLE: start with mask!=0 goes to FLUSH next cycle. Entry clears done, timeout, both done masks, run_cycles and the flush counter. start with mask==0 is ignored.
  - FLUSH: pe_flush_wire = mask for exactly FLUSH_CYC cycles, then RUN. pe_enable=0.
  - RUN: pe_enable = mask; pe_flush_wire=0.
    - Each cycle: send_done_mask |= flag_send & mask; recv_done_mask |= flag_recv & mask.
    - Finish flags may be pulses or levels; capture is sticky.
    - run_cycles increments each RUN cycle and saturates at all-ones.
  - RUN to END with done=1: the cycle after both sticky masks, including the current cycle's flags, equal mask.
  - RUN to END with timeout=1: limit!=0 and run_cycles reaches limit-1 while incomplete, i.e. RUN lasts exactly limit cycles.
  - Simultaneous completion and timeout: done wins.
  - limit==0 disables timeout.
  - END: pe_enable=0, pe_flush_wire=0, busy=0; status holds. start behaves as in IDLE (restart); otherwise stay in END.
- abort in FLUSH or RUN goes to END next cycle with timeout=1 and done=0. abort is ignored in IDLE and END.
- abort takes priority over completion in the same cycle.
- start while busy is ignored.
- busy=1 exactly in FLUSH and RUN.
- Asynchronous rst mid-task immediately drops pe_enable and pe_flush_wire and clears the shadow registers.

Test Plan:
- Write mask=0x0F, send_num=0x000249, limit=100; start. Check pe_flush_wire=0x0F for 4 cycles, then pe_enable=0x0F. Pulse send and recv flags 0x0F at run cycle 10. Expect done=1, timeout=0, run_cycles=11, pe_enable=0 the next cycle.
- mask=0xFF, limit=20; only PEs 0-6 finish. Expect timeout=1, done=0, run_cycles=20, send_done_mask=0x7F.
- Flags arrive staggered: PE0 send at cycle 3, recv at cycle 8; others earlier, non-enabled bits toggling. Expect masks ignore non-enabled bits and done only after cycle 8.
- Config write to address 1 during RUN and start pulse during RUN: shadow and state unchanged. Abort at run cycle 5: END with timeout=1, run_cycles=5.
- Write dst_seq words 5..10 with distinct patterns; check pe_dst_seq_wire bit placement. start with mask=0 stays IDLE.
- Assert rst during FLUSH: all outputs 0 immediately, state IDLE; new config and start run normally after release.
